// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared instruction type, NOP constant and fetch queue entry for the IF stage
package fetch_stage_pkg;
  typedef logic [31:0] instruction_type;
  localparam instruction_type NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    instruction_type instr;
    logic [31:0]     pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_stage_fetch_queue.sv
// fetch_queue: synchronous FIFO of fetched {instruction, pc} entries, flush beats push
module fetch_queue
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr      <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  assign head  = mem[rd];
  assign full  = count[AW];
  assign empty = count == '0;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner issuing in-order imem reads with credit flow control, stale-response dropping on redirect
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [31:0]     imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  input  logic            stall,
  output logic            instr_valid,
  output instruction_type instruction,
  output logic [31:0]     pc_out
);
  localparam int W = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [W-1:0] CAP = QUEUE_DEPTH[W-1:0];
  logic [31:0] fetch_pc, rsp_pc, new_pc;
  logic [W-1:0] outstanding, drop_cnt, count, inc, dec;
  logic [W:0] credit;
  logic accept, drop, push, pop, full, empty;
  fetch_entry_t head;
  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .flush(redirect_valid),
    .din('{instr: imem_rsp_data, pc: rsp_pc}), .head(head), .count(count), .full(full), .empty(empty)
  );
  assign new_pc         = {redirect_pc[31:2], 2'b00};
  assign credit         = {1'b0, outstanding} + {1'b0, count} - {{W{1'b0}}, pop};
  assign imem_req_valid = reset_n && !redirect_valid && credit < {1'b0, CAP};
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign drop           = imem_rsp_valid && drop_cnt != '0;
  assign push           = imem_rsp_valid && !drop && !redirect_valid;
  assign instr_valid    = !empty && !redirect_valid;
  assign pop            = instr_valid && !stall;
  assign instruction    = instr_valid ? head.instr : NOP_INSTR;
  assign pc_out         = instr_valid ? head.pc : 32'h0;
  assign inc            = {{(W-1){1'b0}}, accept};
  assign dec            = {{(W-1){1'b0}}, imem_rsp_valid};
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + inc - dec;
      if (redirect_valid) begin
        fetch_pc <= new_pc;
        rsp_pc   <= new_pc;
        drop_cnt <= outstanding - dec;
      end else begin
        fetch_pc <= accept ? fetch_pc + 32'd4 : fetch_pc;
        rsp_pc   <= push ? rsp_pc + 32'd4 : rsp_pc;
        drop_cnt <= drop ? drop_cnt - dec : drop_cnt;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(push && full && !pop)) else $error("fetch queue overflow");
      assert (outstanding <= CAP) else $error("outstanding exceeds queue depth");
      assert (drop_cnt <= outstanding) else $error("drop_cnt exceeds outstanding");
    end
  end
endmodule
